// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 host transmitter
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } state_t;

    localparam int FRAME_BITS = 10;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - 2-flop synchroniser with falling-edge pulse
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to 1: both PS/2 lines idle high when released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command byte transmitter
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES    = 5000,
    parameter int START_HOLD_CYCLES = 50,
    parameter int TIMEOUT_CYCLES    = 750000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int CNT_MAX = max3(INHIBIT_CYCLES, START_HOLD_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(START_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       BIT_LAST  = 4'(FRAME_BITS - 1);

    logic clk_s, clk_fall, dat_s, dat_fall_unused;

    ps2_sync_edge u_sync_clk (
        .clk     (clk),
        .rst_n   (reset_n),
        .d_i     (ps2_clk_in),
        .level_o (clk_s),
        .fall_o  (clk_fall)
    );

    ps2_sync_edge u_sync_dat (
        .clk     (clk),
        .rst_n   (reset_n),
        .d_i     (ps2_dat_in),
        .level_o (dat_s),
        .fall_o  (dat_fall_unused)
    );

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [3:0]            bit_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic clk_oe_q, dat_oe_q, busy_q, ready_q, done_q, err_q;

    // Outputs are registered alongside the state they belong to, so each
    // transition also loads the output values of the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            frame_q  <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    ready_q  <= 1'b1;
                    if (tx_valid && ready_q) begin
                        frame_q  <= {1'b1, odd_parity(tx_data), tx_data};
                        cnt_q    <= '0;
                        bit_q    <= '0;
                        state_q  <= INHIBIT;
                        clk_oe_q <= 1'b1;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                    end
                end
                INHIBIT: begin
                    if (cnt_q == INH_LAST) begin
                        cnt_q    <= '0;
                        state_q  <= START;
                        dat_oe_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                START: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q    <= '0;
                        state_q  <= SEND;
                        clk_oe_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SEND, ACK, WAIT_IDLE: begin
                    // Timeout spans the whole device-clocked phase and wins over a fall.
                    if (cnt_q == TO_LAST) begin
                        cnt_q    <= '0;
                        state_q  <= ERR;
                        err_q    <= 1'b1;
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (state_q == SEND) begin
                            if (clk_fall) begin
                                dat_oe_q <= ~frame_q[bit_q];
                                bit_q    <= bit_q + 4'd1;
                                if (bit_q == BIT_LAST) begin
                                    state_q <= ACK;
                                end
                            end
                        end else if (state_q == ACK) begin
                            if (clk_fall) begin
                                if (dat_s) begin
                                    cnt_q   <= '0;
                                    state_q <= ERR;
                                    err_q   <= 1'b1;
                                end else begin
                                    state_q <= WAIT_IDLE;
                                end
                            end
                        end else if (clk_s && dat_s) begin
                            cnt_q   <= '0;
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE, ERR: begin
                    state_q  <= IDLE;
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_ready   = ready_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;
    assign tx_err     = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int HOLD = 4;
    localparam int TO   = 2000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic       busy, tx_done, tx_err;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit mon_en = 1'b0;

    ps2_host_tx #(
        .INHIBIT_CYCLES    (INH),
        .START_HOLD_CYCLES (HOLD),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    // Open-drain wired-AND of host and device drivers.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Line levels the device must see: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int          ones;
        logic [10:0] f;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Per-cycle timeline model, driven by time elapsed since the accepted request.
    int t = 0;
    bit active = 1'b0;
    bit pend = 1'b0;
    bit after_end = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (tx_done) done_cnt++;
            if (tx_err) err_cnt++;
        end
        if (!reset_n || !mon_en) begin
            active = 1'b0; pend = 1'b0; after_end = 1'b0; t = 0;
        end else begin
            if (pend) begin
                active = 1'b1; t = 1;
            end else if (active) begin
                t++;
            end
            check("mon_done_err_excl", 32'(tx_done & tx_err), 32'd0);
            if (after_end) begin
                check("mon_end_busy", 32'(busy), 32'd0);
                check("mon_end_ready", 32'(tx_ready), 32'd1);
                active = 1'b0; after_end = 1'b0;
            end else if (active) begin
                check("mon_busy", 32'(busy), 32'd1);
                check("mon_ready", 32'(tx_ready), 32'd0);
                if (t <= INH)
                    check("mon_inhibit_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b10);
                else if (t <= INH + HOLD)
                    check("mon_start_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b11);
                else if (!tx_done && !tx_err)
                    check("mon_send_clk_oe", 32'(ps2_clk_oe), 32'd0);
                if (t == INH + HOLD + 1)
                    check("mon_start_bit_held", 32'(ps2_dat_oe), 32'd1);
                if (tx_done || tx_err) begin
                    check("mon_end_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);
                    after_end = 1'b1;
                end
            end else begin
                check("mon_idle_busy", 32'(busy), 32'd0);
                check("mon_idle_ready", 32'(tx_ready), 32'd1);
                check("mon_idle_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);
                check("mon_idle_pulses", 32'({tx_done, tx_err}), 32'b00);
            end
            pend = tx_valid && tx_ready;
        end
    end

    task automatic request(input logic [7:0] d, input int spam);
        @(posedge clk); #2;
        check("req_ready", 32'(tx_ready), 32'd1);
        tx_data = d; tx_valid = 1'b1;
        @(posedge clk); #2;
        tx_data = ~d; tx_valid = (spam != 0);
        repeat (spam) @(posedge clk);
        #2 tx_valid = 1'b0;
    endtask

    task automatic device_frame(input bit ack, input int abort_fall, input logic abort_exp,
                                output logic [10:0] smp, output bit ok);
        int n;
        smp = '0; ok = 1'b0; n = 0;
        while (!(busy && !ps2_clk_oe) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin fail_bound("dev_wait_release"); return; end
        repeat (10) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            smp[i] = ps2_dat_in;
            dev_clk_low = 1'b1;
            if (i == 10 && ack) dev_dat_low = 1'b1;
            if (i + 1 == abort_fall) begin
                repeat (10) @(negedge clk);
                check("abort_pre_dat_oe", 32'(ps2_dat_oe), 32'(abort_exp));
                #1 reset_n = 1'b0; mon_en = 1'b0;
                #1 check("abort_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);
                check("abort_pulses", 32'({tx_done, tx_err, busy}), 32'b000);
                dev_clk_low = 1'b0;
                return;
            end
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0; dev_dat_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        ok = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit ack, input int spam,
                             input string tag, output logic [10:0] smp);
        bit ok;
        int d0, e0, n;
        d0 = done_cnt; e0 = err_cnt;
        request(d, spam);
        device_frame(ack, 0, 1'b0, smp, ok);
        if (ok) check({tag, "_frame_vs_model"}, 32'(smp), 32'(model_frame(d)));
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        if (busy) fail_bound({tag, "_wait_idle"});
        repeat (2) @(negedge clk);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
        check({tag, "_err_pulses"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
    endtask

    task automatic release_reset();
        @(posedge clk); #2 reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready_first_cycle", 32'(tx_ready), 32'd0);
        @(posedge clk); #2 mon_en = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);
    endtask

    initial begin
        logic [10:0] smp;
        bit          ok;
        int          n, cyc, d0, e0;

        // Reset with a request held: must be ignored and all outputs low.
        reset_n = 1'b0; tx_valid = 1'b1; tx_data = 8'hED;
        repeat (3) @(negedge clk);
        check("in_rst_outputs",
              32'({ps2_clk_oe, ps2_dat_oe, busy, tx_ready, tx_done, tx_err}), 32'd0);
        @(posedge clk); #2 tx_valid = 1'b0;
        release_reset();

        send_byte(8'hED, 1'b1, 0, "set_leds", smp);
        check("set_leds_literal", 32'(smp), 32'(11'b11111011010));

        send_byte(8'hF4, 1'b1, 5, "enable", smp);
        check("enable_parity", 32'(smp[9]), 32'd0);
        check("enable_stop", 32'(smp[10]), 32'd1);

        send_byte(8'hFF, 1'b1, 0, "reset_cmd", smp);
        check("reset_cmd_parity", 32'(smp[9]), 32'd1);

        // Device never clocks: error exactly TO cycles after clock release.
        d0 = done_cnt; e0 = err_cnt;
        request(8'hF4, 0);
        n = 0;
        while (!(busy && !ps2_clk_oe) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) fail_bound("to_wait_release");
        cyc = 0;
        while (!tx_err && cyc < 3000) begin @(negedge clk); cyc++; end
        check("to_cycles", 32'(cyc), 32'(TO));
        check("to_err_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);
        @(negedge clk);
        check("to_ready_next", 32'(tx_ready), 32'd1);
        repeat (2) @(negedge clk);
        check("to_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("to_done_pulses", 32'(done_cnt - d0), 32'd0);

        send_byte(8'hED, 1'b0, 0, "noack", smp);

        // Reset while data bit 3 of 0xF4 (a 0, so line driven) is on the wire.
        d0 = done_cnt; e0 = err_cnt;
        request(8'hF4, 0);
        device_frame(1'b1, 4, 1'b1, smp, ok);
        repeat (3) @(negedge clk);
        release_reset();
        check("abort_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

        send_byte(8'h00, 1'b1, 0, "after_abort", smp);
        check("after_abort_literal", 32'(smp), 32'(11'b11000000000));

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
